// File: rtl/sensor_scan_scheduler_pkg.sv
// Shared types and default thresholds for the sensor scan scheduler.
package sensor_scan_pkg;

    typedef enum logic [1:0] {
        CLS_OK   = 2'd0,
        CLS_WARN = 2'd1,
        CLS_HIGH = 2'd2
    } sample_class_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_EVAL,
        ST_NEXT
    } scan_state_t;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ALARM_LO = 192;
    localparam int DEF_SHUT_TH  = 240;
    localparam int DEF_DEBOUNCE = 3;
    localparam int DEF_TIMEOUT  = 15;

endpackage

// File: rtl/sensor_scan_scheduler_if.sv
// Sample request/acknowledge bus between the scheduler and the sensor front-end mux.
interface sensor_scan_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    localparam int CH_W = $clog2(NUM_CH);

    logic              sample_req;
    logic [CH_W-1:0]   sample_ch;
    logic              sample_ack;
    logic [DATA_W-1:0] sample_data;

    modport master (
        output sample_req,
        output sample_ch,
        input  sample_ack,
        input  sample_data
    );

    modport slave (
        input  sample_req,
        input  sample_ch,
        output sample_ack,
        output sample_data
    );
endinterface

// File: rtl/sensor_scan_scheduler_debounce.sv
// Per-channel debouncer: alarm/OK/HIGH run counters, debounced ch_alarm and shutdown trip.
module channel_debounce
    import sensor_scan_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  sample_class_t cls,
    output logic          ch_alarm,
    output logic          alarm_next,
    output logic          high_trip,
    output logic          last_ok
);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE);

    logic [CNT_W-1:0] alarm_cnt, ok_cnt, high_cnt;
    logic [CNT_W-1:0] alarm_cnt_n, ok_cnt_n, high_cnt_n;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == DB_MAX) ? v : v + CNT_W'(1);
    endfunction

    // high_trip looks at the post-update count so shutdown lands in the same edge as ch_alarm
    always_comb begin
        alarm_cnt_n = alarm_cnt;
        ok_cnt_n    = ok_cnt;
        high_cnt_n  = high_cnt;
        alarm_next  = ch_alarm;
        high_trip   = 1'b0;
        if (enable) begin
            if (cls == CLS_OK) begin
                alarm_cnt_n = '0;
                high_cnt_n  = '0;
                ok_cnt_n    = sat_inc(ok_cnt);
            end else begin
                ok_cnt_n    = '0;
                alarm_cnt_n = sat_inc(alarm_cnt);
                high_cnt_n  = (cls == CLS_HIGH) ? sat_inc(high_cnt) : '0;
            end
            if (alarm_cnt_n == DB_MAX) begin
                alarm_next = 1'b1;
            end else if (ok_cnt_n == DB_MAX) begin
                alarm_next = 1'b0;
            end
            high_trip = (high_cnt_n == DB_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm_cnt <= '0;
            ok_cnt    <= '0;
            high_cnt  <= '0;
            ch_alarm  <= 1'b0;
            last_ok   <= 1'b1;
        end else begin
            alarm_cnt <= alarm_cnt_n;
            ok_cnt    <= ok_cnt_n;
            high_cnt  <= high_cnt_n;
            ch_alarm  <= alarm_next;
            if (enable) begin
                last_ok <= (cls == CLS_OK);
            end
        end
    end
endmodule

// File: rtl/sensor_scan_scheduler.sv
// Round-robin sensor scan scheduler with threshold classification, debounce and latched shutdown.
// Define SCAN_TIMEOUT_EN to fail-safe a channel that never acknowledges (evaluated HIGH, sticky fault).
module sensor_scan_scheduler
    import sensor_scan_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ALARM_LO = DEF_ALARM_LO,
    parameter int SHUT_TH  = DEF_SHUT_TH,
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    sensor_scan_scheduler_if.master sample,
    input  logic                   clear,
    output logic [NUM_CH-1:0]      ch_alarm,
    output logic                   alarm,
    output logic                   shut_down,
    output logic                   fault,
    output logic                   scan_done
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);
    localparam logic [DATA_W-1:0] ALARM_LO_V = DATA_W'(ALARM_LO);
    localparam logic [DATA_W-1:0] SHUT_TH_V  = DATA_W'(SHUT_TH);

    scan_state_t       state;
    logic [DATA_W-1:0] data_reg;
    sample_class_t     eval_cls;
    logic [NUM_CH-1:0] ch_en, alarm_next, high_trip, last_ok;
    logic              clear_ok, shut_down_n;

`ifdef SCAN_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    logic [TMR_W-1:0] wait_cnt;
    logic             forced_high;
    logic             fault_r;
    assign fault = fault_r;
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        eval_cls = CLS_OK;
        if (data_reg > SHUT_TH_V) begin
            eval_cls = CLS_HIGH;
        end else if (data_reg >= ALARM_LO_V) begin
            eval_cls = CLS_WARN;
        end
`ifdef SCAN_TIMEOUT_EN
        if (forced_high) begin
            eval_cls = CLS_HIGH;
        end
`endif
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_en[i] = (state == ST_EVAL) && (sample.sample_ch == CH_W'(i));
        channel_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
            .clk        (clk),
            .reset      (reset),
            .enable     (ch_en[i]),
            .cls        (eval_cls),
            .ch_alarm   (ch_alarm[i]),
            .alarm_next (alarm_next[i]),
            .high_trip  (high_trip[i]),
            .last_ok    (last_ok[i])
        );
    end

    // A non-OK evaluation in flight also vetoes clear, so a same-cycle HIGH always wins
    assign clear_ok    = clear && (&last_ok) && !fault &&
                         !((state == ST_EVAL) && (eval_cls != CLS_OK));
    assign shut_down_n = (|high_trip) || (shut_down && !clear_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= ST_IDLE;
            sample.sample_req <= 1'b0;
            sample.sample_ch  <= '0;
            data_reg          <= '0;
            scan_done         <= 1'b0;
            shut_down         <= 1'b0;
            alarm             <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
            wait_cnt          <= '0;
            forced_high       <= 1'b0;
            fault_r           <= 1'b0;
`endif
        end else begin
            scan_done <= 1'b0;
            shut_down <= shut_down_n;
            alarm     <= (|alarm_next) | shut_down_n;
            case (state)
                ST_IDLE: begin
                    sample.sample_req <= 1'b1;
                    state             <= ST_REQ;
                end
                ST_REQ: begin
                    if (sample.sample_ack) begin
                        data_reg          <= sample.sample_data;
                        sample.sample_req <= 1'b0;
                        state             <= ST_EVAL;
`ifdef SCAN_TIMEOUT_EN
                    end else if (wait_cnt == TMR_LAST) begin
                        forced_high       <= 1'b1;
                        fault_r           <= 1'b1;
                        sample.sample_req <= 1'b0;
                        state             <= ST_EVAL;
                    end else begin
                        wait_cnt <= wait_cnt + TMR_W'(1);
`endif
                    end
                end
                ST_EVAL: begin
                    scan_done <= (sample.sample_ch == LAST_CH);
                    state     <= ST_NEXT;
                end
                ST_NEXT: begin
                    sample.sample_ch  <= (sample.sample_ch == LAST_CH) ? '0 : sample.sample_ch + CH_W'(1);
                    sample.sample_req <= 1'b1;
                    state             <= ST_REQ;
`ifdef SCAN_TIMEOUT_EN
                    wait_cnt          <= '0;
                    forced_high       <= 1'b0;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sensor_scan_scheduler.sv
// Self-checking bench for sensor_scan_scheduler: table-driven scans plus hand-written clear/reset/timeout sequences.
module tb_sensor_scan_scheduler;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ch;
        logic [3:0] ch_alarm;
        logic       shut;
        logic       done;
        logic       flt;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic [3:0] ch_alarm;
    logic       alarm, shut_down, fault, scan_done;

    int   total = 0;
    int   bad = 0;
    vec_t sb[$];
    vec_t vecs[52];
    logic [7:0] b_seq[6] = '{8'd241, 8'd241, 8'd240, 8'd241, 8'd241, 8'd241};

    sensor_scan_scheduler_if #(.NUM_CH(4), .DATA_W(8)) bus ();

    sensor_scan_scheduler #(
        .NUM_CH(4), .DATA_W(8), .ALARM_LO(192), .SHUT_TH(240), .DEBOUNCE(3), .TIMEOUT(15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sample    (bus),
        .clear     (clear),
        .ch_alarm  (ch_alarm),
        .alarm     (alarm),
        .shut_down (shut_down),
        .fault     (fault),
        .scan_done (scan_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [7:0] d, input logic [1:0] ch, input logic [3:0] a,
                                input logic sh, input logic dn, input logic fl);
        vec_t v;
        v.data = d; v.ch = ch; v.ch_alarm = a; v.shut = sh; v.done = dn; v.flt = fl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        vec_t v;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard: got empty queue expected a pending sample");
            return;
        end
        v = sb.pop_front();
        check("ch_alarm", ch_alarm, v.ch_alarm);
        check("shut_down", shut_down, v.shut);
        check("alarm", alarm, (|v.ch_alarm) | v.shut);
        check("scan_done", scan_done, v.done);
        check("fault", fault, v.flt);
        check("req_low_in_next", bus.sample_req, 1'b0);
    endtask

    task automatic waitReq(input logic [1:0] exp_ch);
        int n = 0;
        while (!bus.sample_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", bus.sample_req, 1'b1);
        check("req_ch", bus.sample_ch, exp_ch);
    endtask

    task automatic applyStimulus(input vec_t v);
        waitReq(v.ch);
        repeat (2) @(negedge clk);
        check("req_hold", bus.sample_req, 1'b1);
        bus.sample_ack  = 1'b1;
        bus.sample_data = v.data;
        sb.push_back(v);
        @(negedge clk);
        bus.sample_ack  = 1'b0;
        bus.sample_data = 8'($urandom);
        @(negedge clk);
        checkOutput();
    endtask

`ifdef SCAN_TIMEOUT_EN
    task automatic noAckStep(input vec_t v);
        int n = 0;
        waitReq(v.ch);
        while (bus.sample_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("req_hold_cycles", n, 15);
        sb.push_back(v);
        bus.sample_ack  = 1'b1;
        bus.sample_data = 8'd0;
        @(negedge clk);
        bus.sample_ack  = 1'b0;
        checkOutput();
    endtask
`endif

    initial begin
        vec_t v;
        for (int s = 0; s < 13; s++) begin
            for (int c = 0; c < 4; c++) begin
                v.data = 8'd100;
                if (c == 2 && s >= 1 && s <= 3) v.data = 8'd192;
                else if (c == 2 && s >= 4 && s <= 6) v.data = 8'd191;
                else if (c == 1 && s >= 7) v.data = b_seq[s-7];
                v.ch          = 2'(c);
                v.ch_alarm    = 4'b0000;
                v.ch_alarm[2] = (s == 3 && c >= 2) || s == 4 || s == 5 || (s == 6 && c < 2);
                v.ch_alarm[1] = (s == 9 && c >= 1) || s >= 10;
                v.shut        = (s == 12 && c >= 1);
                v.done        = (c == 3);
                v.flt         = 1'b0;
                vecs[s*4+c]   = v;
            end
        end

        reset = 1'b0;
        clear = 1'b0;
        bus.sample_ack  = 1'b0;
        bus.sample_data = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_req", bus.sample_req, 1'b0);
        check("rst_ch", bus.sample_ch, 2'd0);
        check("rst_ch_alarm", ch_alarm, 4'b0000);
        check("rst_alarm", alarm, 1'b0);
        check("rst_shut", shut_down, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_scan_done", scan_done, 1'b0);

        reset = 1'b1;
        @(negedge clk);
        check("first_req", bus.sample_req, 1'b1);
        check("first_ch", bus.sample_ch, 2'd0);

        for (int i = 0; i < 52; i++) applyStimulus(vecs[i]);

        // clear while channel 0 still reads HIGH must be ignored
        applyStimulus(mk(8'd245, 2'd0, 4'b0010, 1'b1, 1'b0, 1'b0));
        clear = 1'b1;
        @(negedge clk);
        check("clear_blocked", shut_down, 1'b1);
        clear = 1'b0;
        applyStimulus(mk(8'd50, 2'd1, 4'b0010, 1'b1, 1'b0, 1'b0));
        applyStimulus(mk(8'd50, 2'd2, 4'b0010, 1'b1, 1'b0, 1'b0));
        applyStimulus(mk(8'd50, 2'd3, 4'b0010, 1'b1, 1'b1, 1'b0));

        applyStimulus(mk(8'd50, 2'd0, 4'b0010, 1'b1, 1'b0, 1'b0));
        clear = 1'b1;
        @(negedge clk);
        check("clear_release", shut_down, 1'b0);
        check("alarm_after_clear", alarm, 1'b1);
        clear = 1'b0;
        applyStimulus(mk(8'd50, 2'd1, 4'b0010, 1'b0, 1'b0, 1'b0));
        applyStimulus(mk(8'd50, 2'd2, 4'b0010, 1'b0, 1'b0, 1'b0));
        applyStimulus(mk(8'd50, 2'd3, 4'b0010, 1'b0, 1'b1, 1'b0));
        applyStimulus(mk(8'd50, 2'd0, 4'b0010, 1'b0, 1'b0, 1'b0));
        applyStimulus(mk(8'd50, 2'd1, 4'b0000, 1'b0, 1'b0, 1'b0));

        // reset in the middle of a request with an ack pending
        waitReq(2'd2);
        bus.sample_ack  = 1'b1;
        bus.sample_data = 8'd250;
        reset = 1'b0;
        #1;
        check("midrst_req", bus.sample_req, 1'b0);
        check("midrst_ch", bus.sample_ch, 2'd0);
        check("midrst_ch_alarm", ch_alarm, 4'b0000);
        check("midrst_alarm", alarm, 1'b0);
        check("midrst_shut", shut_down, 1'b0);
        @(negedge clk);
        bus.sample_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("restart_req", bus.sample_req, 1'b1);
        check("restart_ch", bus.sample_ch, 2'd0);

`ifdef SCAN_TIMEOUT_EN
        for (int k = 1; k <= 3; k++) begin
            for (int c = 0; c < 3; c++) begin
                applyStimulus(mk(8'd100, 2'(c), 4'b0000, 1'b0, 1'b0, k > 1));
            end
            noAckStep(mk(8'd0, 2'd3, (k == 3) ? 4'b1000 : 4'b0000, k == 3, 1'b1, 1'b1));
        end
`else
        for (int c = 0; c < 4; c++) begin
            applyStimulus(mk(8'd100, 2'(c), 4'b0000, 1'b0, c == 3, 1'b0));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sensor_scan_scheduler.md
Name: sensor_scan_scheduler

Overview:
Round-robin scheduler for up to NUM_CH sensor channels sharing one sample interface and one threshold classifier. Requests one reading per channel over a req/ack handshake and classifies it against the alarm and shutdown thresholds. Debounces each channel and drives per-channel alarms plus global alarm and latched shut_down outputs. Sits between the sensor front-end mux and the plant safety logic.

Parameters:
NUM_CH, 4, number of scanned channels (2..16)
DATA_W, 8, reading width
ALARM_LO, 192, reading >= ALARM_LO is WARN class
SHUT_TH, 240, reading > SHUT_TH is HIGH class (must exceed ALARM_LO)
DEBOUNCE, 3, consecutive samples needed to change a channel's state (>=1)
TIMEOUT, 15, max cycles waiting for sample_ack

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
sample_req  out  1  request reading of sample_ch
sample_ch  out  clog2(NUM_CH)  channel being requested
sample_ack  in  1  reading valid on sample_data (one-cycle pulse)
sample_data  in  DATA_W  reading, unsigned
clear  in  1  operator request to release shut_down
ch_alarm  out  NUM_CH  per-channel debounced alarm
alarm  out  1  OR of ch_alarm, or shut_down
shut_down  out  1  latched shutdown
fault  out  1  sticky: some channel timed out
scan_done  out  1  one-cycle pulse after last channel evaluated

Behaviour:
- Reset (reset=0, async): state IDLE, sample_ch=0, sample_req=0, all debounce counters 0, all channel states OK. ch_alarm, alarm, shut_down, fault, scan_done all 0.
- FSM IDLE -> REQ: one cycle after reset release.
- REQ: sample_req=1, sample_ch stable until ack. On sample_ack: register sample_data, deassert sample_req next cycle, go EVAL.
- EVAL (1 cycle): classify the registered sample as HIGH (> SHUT_TH), WARN (>= ALARM_LO and <= SHUT_TH) or OK. Update that channel's debouncer. Then go NEXT.
- NEXT (1 cycle): sample_ch increments, wrapping NUM_CH-1 -> 0. Go REQ. scan_done pulses in the NEXT cycle after channel NUM_CH-1.
- Boundaries: 192 is WARN, 240 is WARN, 241 is HIGH, 191 is OK.
- Latency: ack in cycle t -> EVAL in t+1 -> outputs updated and visible in t+2.
- sample_ack outside REQ is ignored.
- Debouncer, per channel:
  - Alarm counter saturates at DEBOUNCE. It increments on WARN or HIGH and resets on OK.
  - ch_alarm sets when the alarm counter reaches DEBOUNCE.
  - A separate OK counter clears ch_alarm after DEBOUNCE consecutive OK samples.
  - A HIGH counter counts consecutive HIGH samples. When it reaches DEBOUNCE, shut_down sets.
- shut_down is sticky.
  - It clears only when clear=1 in a cycle where every channel's last classification is OK and fault=0. It deasserts the following cycle.
  - Otherwise clear is ignored, including when clear and a new HIGH event occur in the same cycle. Set wins.
- alarm = |ch_alarm | shut_down. All outputs are registered.
- Reset mid-handshake: sample_req drops immediately (async). The pending ack is discarded.

Optional Feature:
Macro SCAN_TIMEOUT_EN.
- Defined: a cycle counter runs in REQ. If TIMEOUT cycles elapse with no ack:
  - The channel is evaluated as HIGH (fail-safe).
  - fault sets and stays set until reset.
  - The FSM goes EVAL.
  - A late ack arriving after the timeout is ignored.
- Undefined: REQ waits indefinitely, and fault is tied to 0.

Decomposition:
- Package sensor_scan_pkg holds:
  - the class enum (OK, WARN, HIGH), 2 bits
  - the FSM state enum (IDLE, REQ, EVAL, NEXT)
  - the default threshold constants
- Sub-module channel_debounce holds the per-channel counters and ch_alarm/high_trip logic. It is instantiated NUM_CH times via generate. Only the EVAL-selected instance is enabled.

Test Plan:
- Reset release, sensor acks each request after 2 cycles with data 100 on all channels -> sample_ch cycles 0,1,2,3,0. scan_done every 4th NEXT. All alarms 0.
- Channel 2 returns 192 for 3 consecutive scans -> ch_alarm[2]=1 and alarm=1 two cycles after the 3rd ack. Then returns 191 for 3 scans -> ch_alarm[2]=0. shut_down stays 0 throughout.
- Channel 1 returns 241, 241, 240, 241, 241, 241 -> shut_down=1 only after the 6th sample. Then data 50 everywhere with clear=1 -> shut_down=0 one cycle after clear.
- While shut_down=1 and channel 0 still reads 245, pulse clear -> shut_down stays 1.
- With SCAN_TIMEOUT_EN, channel 3 never acks -> sample_req held 15 cycles, then fault=1. Channel 3 counts as HIGH, so 3 scans later shut_down=1. A late ack is ignored.
- Assert reset low mid-REQ -> sample_req, all outputs 0 immediately. Scan restarts at channel 0 after release.
